// File: rtl/adc_spi_resp_if.sv
// SPI slave-side bundle of the A2D responder: serial lines plus the client-side
// conversion/channel handshake.
interface adc_spi_resp_if;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [11:0] rd_data;
    logic [2:0]  chnnl;
    logic        cmd_vld;
    logic        frm_err;

    modport slave (
        input  SS_n, SCLK, MOSI, rd_data,
        output MISO, chnnl, cmd_vld, frm_err
    );

    modport master (
        output SS_n, SCLK, MOSI, rd_data,
        input  MISO, chnnl, cmd_vld, frm_err
    );
endinterface

// File: rtl/adc_spi_resp.sv
// ADC128S-style SPI responder: receives a 16-bit command frame, latches the channel,
// and returns the conversion value for the channel requested in the previous frame.
module adc_spi_resp (
    input  logic          clk,
    input  logic          rst,
    adc_spi_resp_if.slave bus
);

    localparam logic [4:0] FRAME_BITS = 5'd16;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t      r_state, w_state_nxt;

    logic        r_ss_ff1, r_ss_ff2, r_ss_ff3;
    logic        r_sclk_ff1, r_sclk_ff2, r_sclk_ff3;
    logic        r_mosi_ff1, r_mosi_ff2;
    logic [1:0]  r_settle;

    // Only bits [13:11] of the command are ever used, so the upper two are not kept.
    logic [13:0] r_rx_shft;
    logic [15:0] r_tx_shft;
    logic [4:0]  r_bit_cnt;
    logic [2:0]  r_chnnl;
    logic        r_cmd_vld, r_frm_err;

    logic        w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
    logic        w_load, w_done_ok, w_done_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss_ff1   <= 1'b1;
            r_ss_ff2   <= 1'b1;
            r_ss_ff3   <= 1'b1;
            r_sclk_ff1 <= 1'b1;
            r_sclk_ff2 <= 1'b1;
            r_sclk_ff3 <= 1'b1;
            r_mosi_ff1 <= 1'b0;
            r_mosi_ff2 <= 1'b0;
            r_settle   <= 2'd0;
        end else begin
            r_ss_ff1   <= bus.SS_n;
            r_ss_ff2   <= r_ss_ff1;
            r_ss_ff3   <= r_ss_ff2;
            r_sclk_ff1 <= bus.SCLK;
            r_sclk_ff2 <= r_sclk_ff1;
            r_sclk_ff3 <= r_sclk_ff2;
            r_mosi_ff1 <= bus.MOSI;
            r_mosi_ff2 <= r_mosi_ff1;
            if (r_settle != 2'd3)
                r_settle <= r_settle + 2'd1;
        end
    end

    // A start is only trusted once the SS_n chain holds real samples, so SS_n held
    // low across reset release does not fake a falling edge.
    assign w_ss_fall   = (r_settle == 2'd3) & r_ss_ff3 & ~r_ss_ff2;
    assign w_ss_rise   = ~r_ss_ff3 & r_ss_ff2;
    assign w_sclk_rise = ~r_sclk_ff3 & r_sclk_ff2;
    assign w_sclk_fall = r_sclk_ff3 & ~r_sclk_ff2;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done_ok   = 1'b0;
        w_done_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_fall)
                    w_state_nxt = LOAD;
            end
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (w_ss_rise) begin
                    w_state_nxt = IDLE;
                    if (r_bit_cnt == FRAME_BITS)
                        w_done_ok = 1'b1;
                    else
                        w_done_err = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_shft <= 16'd0;
            r_rx_shft <= 14'd0;
            r_bit_cnt <= 5'd0;
            r_chnnl   <= 3'd0;
            r_cmd_vld <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_cmd_vld <= w_done_ok;
            r_frm_err <= w_done_err;
            if (w_done_ok)
                r_chnnl <= r_rx_shft[13:11];
            if (w_load) begin
                r_tx_shft <= {4'b0000, bus.rd_data};
                r_bit_cnt <= 5'd0;
            end else if (r_state == SHIFT) begin
                if (w_sclk_rise && (r_bit_cnt != FRAME_BITS)) begin
                    r_rx_shft <= {r_rx_shft[12:0], r_mosi_ff2};
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
                // The first falling edge precedes bit 1, and after bit 16 the word is spent.
                if (w_sclk_fall && (r_bit_cnt != 5'd0) && (r_bit_cnt != FRAME_BITS))
                    r_tx_shft <= {r_tx_shft[14:0], 1'b0};
            end
        end
    end

    assign bus.MISO    = ~r_ss_ff2 & r_tx_shft[15];
    assign bus.chnnl   = r_chnnl;
    assign bus.cmd_vld = r_cmd_vld;
    assign bus.frm_err = r_frm_err;

endmodule
